capacitive_touch_scanner: RTL and testbench
===========================================

Name: capacitive_touch_scanner

Overview:
- Sensor-side counterpart to the LED output path: drives the shared charge line `capacitive_sensors_out` and measures how long each of the 9 `capacitive_sensors_in` pads takes to discharge.
- Converts the per-pad discharge times into debounced touch flags and one-cycle hit pulses.
- The skeleton's memory-mapped I/O reads these flags so the game code can detect a whacked mole.

Parameters:
- NUM_PADS, 9: number of sensor pads.
- CNT_W, 10: width of the per-pad discharge counter.
- CHARGE_CYCLES, 64: cycles the charge line is held high.
- TIMEOUT_CYCLES, 1023: maximum measure length; must be ≤ 2^CNT_W-1.
- GAP_CYCLES, 256: idle cycles between scans.
- DEBOUNCE, 3: consecutive agreeing scans needed to change a touch flag.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- scan_enable  in  1  level; when high, scans run back-to-back.
- threshold  in  CNT_W  count at or above which a pad reads as touched.
- capacitive_sensors_in  in  NUM_PADS  raw pad inputs; asynchronous.
- capacitive_sensors_out  out  1  charge drive.
- touch_state  out  NUM_PADS  debounced touch flags.
- touch_pulse  out  NUM_PADS  one-cycle pulse on a 0→1 change of touch_state.
- pad_fault  out  NUM_PADS  pad still high at timeout in the last scan.
- scan_done  out  1  one-cycle pulse at the end of each scan.
- count_sel  in  4  pad index for the raw-count readback.
- count_value  out  CNT_W  last latched count of pad count_sel; 0 if count_sel ≥ NUM_PADS.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs, counters, debounce history and synchronizers go to 0.
  - FSM goes to IDLE; capacitive_sensors_out is 0 immediately.
- Every input bit passes through a 2-flop synchronizer before any use; this adds 2 cycles to each count.
- FSM IDLE:
  - sense_out=0.
  - scan_enable=1 → CHARGE on the next cycle; clear all pad counters.
- FSM CHARGE:
  - sense_out=1 for exactly CHARGE_CYCLES cycles, then → MEASURE.
- FSM MEASURE:
  - sense_out=0; shared timer counts from 0.
  - Each pad counter increments on every cycle its synced input is 1, and freezes once that input has been seen 0.
  - Exit to EVAL when every pad has frozen, or when timer = TIMEOUT_CYCLES-1.
  - A pad still high at exit sets its pad_fault bit and keeps count = TIMEOUT_CYCLES.
- FSM EVAL (1 cycle):
  - raw[i] = (count[i] ≥ threshold) & ~fault[i]; threshold is sampled in this cycle.
  - Shift raw[i] into the per-pad DEBOUNCE history.
  - History all 1 → touch_state[i]=1; all 0 → 0; otherwise hold.
  - Latch counts for readback.
  - In the following cycle: touch_state and pad_fault are updated, scan_done=1, touch_pulse = new & ~old for exactly one cycle.
  - → GAP.
- FSM GAP:
  - Wait GAP_CYCLES, then → IDLE.
  - A continuously high scan_enable therefore yields one scan every CHARGE_CYCLES + measure + 1 + GAP_CYCLES + 1 cycles.
- scan_enable dropped mid-scan: the current scan completes, including its EVAL outputs, then the FSM stays in IDLE.
- Counters never wrap; they saturate at TIMEOUT_CYCLES.
- A pad already 0 at MEASURE start gets count 2 (synchronizer lag) or less; it reads as untouched for any threshold > 2.
- pad_fault holds its value until the next EVAL.
- threshold=0: every non-faulted pad reads as touched.

Decomposition:
- Shared package (whackamole_io_pkg):
  - FSM state encoding IDLE/CHARGE/MEASURE/EVAL/GAP.
  - Default NUM_PADS and CNT_W constants, shared with the LED driver.
- Sub-module pad_discharge_counter, instantiated NUM_PADS times:
  - Contains the 2-flop synchronizer, saturating counter and freeze flag.
  - Inputs: clear, measure_en.
  - Outputs: count, still_high.
- Top level holds the FSM, shared timer, comparators, debounce history, pulse generation and readback mux.

Test Plan:
- Bench parameters for all scenarios: CHARGE_CYCLES=4, GAP_CYCLES=8, threshold=20, DEBOUNCE=3.
- Reset check: assert reset low mid-CHARGE → sense_out=0 within the same cycle; all outputs 0; FSM idle after release with scan_enable=0.
- Charge timing: set scan_enable=1 → sense_out high exactly 4 cycles, then MEASURE starts; scan_done pulses once per scan.
- Count accuracy: pad 0 high for 10 cycles after sense_out falls, pad 5 for 30 cycles → count_value(sel=0)=12, count_value(sel=5)=32; after 3 scans touch_state=9'b000100000, touch_pulse[5] high exactly 1 cycle.
- Debounce: pad 5 pattern touched, untouched, touched, touched, touched across scans → touch_state[5] rises only at the end of the 5th scan; a single untouched scan afterwards does not clear it.
- Timeout/fault: pad 8 held high permanently → MEASURE ends at 1023 cycles, pad_fault[8]=1, count_value(sel=8)=1023, touch_state[8] stays 0.
- Mid-scan disable: drop scan_enable during MEASURE → that scan's scan_done still pulses, then sense_out stays 0; count_sel=12 → count_value=0.

Source files
------------

// File: rtl/whackamole_io_pkg.sv
// Shared constants and scan FSM encoding for the whack-a-mole I/O blocks
// (touch scanner and LED driver).
package whackamole_io_pkg;

    localparam int NUM_PADS_DEF = 9;
    localparam int CNT_W_DEF    = 10;
    localparam int TMR_W        = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHARGE,
        ST_MEASURE,
        ST_EVAL,
        ST_GAP
    } scan_state_e;

endpackage

// File: rtl/pad_discharge_counter.sv
// One sensor pad: 2-flop synchronizer plus a saturating discharge counter
// that freezes the first time the synced pad is seen low during a measure.
module pad_discharge_counter #(
    parameter int CNT_W          = 10,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pad_i,
    input  logic             clear_i,
    input  logic             measure_en_i,
    output logic [CNT_W-1:0] count_o,
    output logic             still_high_o
);

    logic             sync1_q, sync2_q;
    logic             frozen_q, frozen_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d  = count_q;
        frozen_d = frozen_q;
        if (clear_i) begin
            count_d  = '0;
            frozen_d = 1'b0;
        end else if (measure_en_i && !frozen_q) begin
            if (!sync2_q) begin
                frozen_d = 1'b1;
            end else if (count_q < CNT_W'(TIMEOUT_CYCLES)) begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            frozen_q <= 1'b0;
            count_q  <= '0;
        end else begin
            sync1_q  <= pad_i;
            sync2_q  <= sync1_q;
            frozen_q <= frozen_d;
            count_q  <= count_d;
        end
    end

    assign count_o      = count_q;
    assign still_high_o = ~frozen_q;

endmodule

// File: rtl/capacitive_touch_scanner.sv
// Capacitive pad scanner: charges all pads, times their discharge, and turns
// the counts into debounced touch flags, hit pulses and timeout faults.
module capacitive_touch_scanner
    import whackamole_io_pkg::*;
#(
    parameter int NUM_PADS       = NUM_PADS_DEF,
    parameter int CNT_W          = CNT_W_DEF,
    parameter int CHARGE_CYCLES  = 64,
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int GAP_CYCLES     = 256,
    parameter int DEBOUNCE       = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                scan_enable,
    input  logic [CNT_W-1:0]    threshold,
    input  logic [NUM_PADS-1:0] capacitive_sensors_in,
    output logic                capacitive_sensors_out,
    output logic [NUM_PADS-1:0] touch_state,
    output logic [NUM_PADS-1:0] touch_pulse,
    output logic [NUM_PADS-1:0] pad_fault,
    output logic                scan_done,
    input  logic [3:0]          count_sel,
    output logic [CNT_W-1:0]    count_value
);

    scan_state_e      state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             clear, measure_en, eval_en;

    logic [NUM_PADS-1:0][CNT_W-1:0]    cnt;
    logic [NUM_PADS-1:0]               still_high;
    logic [NUM_PADS-1:0]               raw;
    logic [NUM_PADS-1:0][DEBOUNCE-1:0] hist_q, hist_d;
    logic [NUM_PADS-1:0]               touch_q, touch_d;
    logic [NUM_PADS-1:0]               fault_q, pulse_q;
    logic [NUM_PADS-1:0][CNT_W-1:0]    lat_q;
    logic                              done_q;

    for (genvar g = 0; g < NUM_PADS; g++) begin : g_pad
        pad_discharge_counter #(
            .CNT_W          (CNT_W),
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
        ) u_pad (
            .clock        (clock),
            .reset        (reset),
            .pad_i        (capacitive_sensors_in[g]),
            .clear_i      (clear),
            .measure_en_i (measure_en),
            .count_o      (cnt[g]),
            .still_high_o (still_high[g])
        );
    end

    // One shared timer serves charge, measure and gap; it restarts on every state change.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q + TMR_W'(1);
        clear      = 1'b0;
        measure_en = 1'b0;
        eval_en    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (scan_enable) begin
                    state_d = ST_CHARGE;
                    clear   = 1'b1;
                end
            end
            ST_CHARGE: begin
                if (timer_q == TMR_W'(CHARGE_CYCLES - 1)) begin
                    state_d = ST_MEASURE;
                    timer_d = '0;
                end
            end
            ST_MEASURE: begin
                measure_en = 1'b1;
                if (~|still_high || timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_EVAL;
                    timer_d = '0;
                end
            end
            ST_EVAL: begin
                eval_en = 1'b1;
                state_d = ST_GAP;
                timer_d = '0;
            end
            ST_GAP: begin
                if (timer_q == TMR_W'(GAP_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // A flag only flips once the whole history agrees; mixed history holds it.
    always_comb begin
        raw     = '0;
        hist_d  = hist_q;
        touch_d = touch_q;
        for (int i = 0; i < NUM_PADS; i++) begin
            raw[i]    = (cnt[i] >= threshold) && !still_high[i];
            hist_d[i] = {hist_q[i][DEBOUNCE-2:0], raw[i]};
            if (&hist_d[i]) begin
                touch_d[i] = 1'b1;
            end else if (~|hist_d[i]) begin
                touch_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hist_q  <= '0;
            touch_q <= '0;
            fault_q <= '0;
            lat_q   <= '0;
            pulse_q <= '0;
            done_q  <= 1'b0;
        end else begin
            pulse_q <= '0;
            done_q  <= 1'b0;
            if (eval_en) begin
                hist_q  <= hist_d;
                touch_q <= touch_d;
                fault_q <= still_high;
                lat_q   <= cnt;
                pulse_q <= touch_d & ~touch_q;
                done_q  <= 1'b1;
            end
        end
    end

    always_comb begin
        count_value = '0;
        for (int i = 0; i < NUM_PADS; i++) begin
            if (count_sel == 4'(i)) begin
                count_value = lat_q[i];
            end
        end
    end

    assign capacitive_sensors_out = (state_q == ST_CHARGE);
    assign touch_state            = touch_q;
    assign touch_pulse            = pulse_q;
    assign pad_fault              = fault_q;
    assign scan_done              = done_q;

endmodule

// File: tb/tb_capacitive_touch_scanner.sv
// Randomized bench for capacitive_touch_scanner; pads are modelled as RC lines
// that stay high a set number of cycles after the charge drive drops.
module tb_capacitive_touch_scanner;

    localparam int NP  = 9;
    localparam int CW  = 10;
    localparam int CHG = 4;
    localparam int TMO = 1023;
    localparam int GAP = 8;
    localparam int DEB = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic          scan_enable;
    logic [CW-1:0] threshold;
    logic [NP-1:0] pads;
    logic          sense;
    logic [NP-1:0] touch_state, touch_pulse, pad_fault;
    logic          scan_done;
    logic [3:0]    count_sel;
    logic [CW-1:0] count_value;

    capacitive_touch_scanner #(
        .NUM_PADS(NP), .CNT_W(CW), .CHARGE_CYCLES(CHG),
        .TIMEOUT_CYCLES(TMO), .GAP_CYCLES(GAP), .DEBOUNCE(DEB)
    ) dut (
        .clock                  (clock),
        .reset                  (reset),
        .scan_enable            (scan_enable),
        .threshold              (threshold),
        .capacitive_sensors_in  (pads),
        .capacitive_sensors_out (sense),
        .touch_state            (touch_state),
        .touch_pulse            (touch_pulse),
        .pad_fault              (pad_fault),
        .scan_done              (scan_done),
        .count_sel              (count_sel),
        .count_value            (count_value)
    );

    always #5 clock = ~clock;

    int errs = 0, checks = 0;
    int cyc = 0;
    int k = 0;
    int dly [NP];  // cycles a pad stays high after the drive falls; -1 = stuck high

    always @(posedge clock) cyc <= cyc + 1;

    // Pad model: high while charged, then high for dly[i] more cycles.
    always @(negedge clock) begin
        for (int i = 0; i < NP; i++)
            pads[i] <= sense || (dly[i] < 0) || (k < dly[i]);
        k <= sense ? 0 : k + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference model, kept in terms of scan outcomes.
    int            e_cnt [NP];
    logic [NP-1:0] e_touch, e_pulse, e_fault;
    bit            m_last [NP];
    int            m_run  [NP];

    task automatic model_reset();
        e_touch = '0; e_pulse = '0; e_fault = '0;
        for (int i = 0; i < NP; i++) begin
            e_cnt[i] = 0; m_last[i] = 1'b0; m_run[i] = DEB;
        end
    endtask

    task automatic model_scan();
        logic [NP-1:0] old;
        bit flt, r;
        old = e_touch;
        for (int i = 0; i < NP; i++) begin
            // synced input lags by 2 cycles; a pad never seen low by the last measure cycle faults
            flt        = (dly[i] < 0) || (dly[i] + 2 >= TMO);
            e_cnt[i]   = flt ? TMO : dly[i] + 2;
            e_fault[i] = flt;
            r          = (e_cnt[i] >= int'(threshold)) && !flt;
            if (r == m_last[i]) m_run[i]++;
            else begin m_last[i] = r; m_run[i] = 1; end
            if (m_run[i] >= DEB) e_touch[i] = r;
        end
        e_pulse = e_touch & ~old;
    endtask

    task automatic do_reset();
        @(negedge clock); reset = 1'b0; scan_enable = 1'b0;
        @(negedge clock); reset = 1'b1;
        model_reset();
    endtask

    // mode 0: drop enable during charge, 1: keep enable high, 2: drop during measure
    task automatic scan(input int mode, input int probe, output int mt, output int done_cyc);
        int ch = 0, budget = 0;
        bit got = 0;
        mt = 0; done_cyc = 0;
        scan_enable = 1'b1;
        while (!got && budget < 3000) begin
            @(negedge clock); budget++;
            if (scan_done) got = 1;
            else if (sense) begin ch++; if (mode == 0) scan_enable = 1'b0; end
            else if (ch > 0) begin mt++; if (mode == 2) scan_enable = 1'b0; end
        end
        if (!got) begin
            chk("scan_timeout", 0, 1);
            return;
        end
        done_cyc = cyc;
        model_scan();
        chk("charge_len", ch, CHG);
        chk("touch_state", touch_state, e_touch);
        chk("touch_pulse", touch_pulse, e_pulse);
        chk("pad_fault", pad_fault, e_fault);
        count_sel = 4'(probe);
        #1 chk("count_probe", count_value, e_cnt[probe]);
        @(negedge clock);
        chk("done_clr", scan_done, 0);
        chk("pulse_clr", touch_pulse, 0);
        if (mode != 1) begin
            for (int i = 0; i < NP; i++) begin
                @(negedge clock);
                count_sel = 4'(i);
                #1 chk($sformatf("count%0d", i), count_value, e_cnt[i]);
            end
        end
    endtask

    initial begin
        int mt, dc0, dc1, bad;
        logic [5:0] pat;
        reset = 1'b0; scan_enable = 1'b0; threshold = CW'(20); count_sel = '0;
        for (int i = 0; i < NP; i++) dly[i] = 0;
        model_reset();
        repeat (3) @(negedge clock);
        chk("rst_sense", sense, 0);
        chk("rst_touch", touch_state, 0);
        chk("rst_pulse", touch_pulse, 0);
        chk("rst_fault", pad_fault, 0);
        chk("rst_done", scan_done, 0);
        chk("rst_count", count_value, 0);
        reset = 1'b1;

        // Reset landing mid-charge must drop the drive immediately.
        scan_enable = 1'b1;
        bad = 1;
        for (int n = 0; n < 20 && bad; n++) begin
            @(negedge clock);
            if (sense) bad = 0;
        end
        chk("charge_seen", bad, 0);
        #2 reset = 1'b0;
        #1 chk("rst_async_sense", sense, 0);
        chk("rst_async_done", scan_done, 0);
        @(negedge clock); scan_enable = 1'b0;
        @(negedge clock); reset = 1'b1;
        model_reset();
        bad = 0;
        repeat (20) begin
            @(negedge clock);
            if (sense || scan_done) bad++;
        end
        chk("idle_after_reset", bad, 0);

        // Count accuracy: pad0 10 cycles, pad5 30 cycles.
        dly[0] = 10; dly[5] = 30;
        repeat (3) scan(0, 5, mt, dc0);
        chk("touch_after3", touch_state, 9'b000100000);
        count_sel = 4'd0;
        #1 chk("count_pad0", count_value, 12);
        count_sel = 4'd5;
        #1 chk("count_pad5", count_value, 32);

        // Debounce on pad5: T U T T T U.
        do_reset();
        for (int i = 0; i < NP; i++) dly[i] = 0;
        pat = 6'b011101;
        for (int s = 0; s < 6; s++) begin
            dly[5] = pat[s] ? 30 : 5;
            scan(0, 5, mt, dc0);
            chk($sformatf("deb_scan%0d", s), touch_state[5], (s >= 4) ? 1 : 0);
        end

        // Timeout: pad8 stuck high, two back-to-back scans.
        do_reset();
        for (int i = 0; i < NP; i++) dly[i] = $urandom_range(0, 30);
        dly[8] = -1;
        scan(1, 8, mt, dc0);
        chk("tmo_meas_len", mt, TMO + 1);
        scan(1, 8, mt, dc1);
        chk("tmo_meas_len2", mt, TMO + 1);
        chk("scan_period", dc1 - dc0, CHG + TMO + 1 + GAP + 1);
        scan_enable = 1'b0;
        repeat (GAP + 3) @(negedge clock);
        dly[8] = 5;
        scan(0, 8, mt, dc0);

        // Randomized scans, including threshold = 0.
        for (int s = 0; s < 10; s++) begin
            threshold = (s == 3) ? CW'(0) : CW'($urandom_range(5, 45));
            for (int i = 0; i < NP; i++)
                dly[i] = ($urandom_range(0, 15) == 0) ? -1 : int'($urandom_range(0, 45));
            scan(0, $urandom_range(0, NP - 1), mt, dc0);
        end

        // Enable dropped during measure: scan finishes, then stays idle.
        threshold = CW'(20);
        for (int i = 0; i < NP; i++) dly[i] = $urandom_range(0, 40);
        scan(2, 0, mt, dc0);
        count_sel = 4'd12;
        #1 chk("count_sel_oob", count_value, 0);
        bad = 0;
        repeat (40) begin
            @(negedge clock);
            if (sense || scan_done) bad++;
        end
        chk("idle_after_drop", bad, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
